sys_reset_seq: RTL and testbench

Parametrised reset sequencer that supersedes the fixed `sys_resetn = ~reset` path of the system master. It synchronises the board reset and N asynchronous "ready" qualifiers (PLL locked, PCIe link-up, ...). It then releases NUM_DOMAINS active-low resets in index order with programmable hold and inter-stage gaps. It also supports a software-requested full re-sequence and records loss of any qualifier during operation.

---
 rtl/sys_reset_seq.sv | 180 ++++++++++++++++++
 tb/tb_sys_reset_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_reset_seq.sv
// sys_reset_seq: reset sequencer for the system master.
// Synchronises the board reset and the asynchronous ready qualifiers. Once
// every qualifier is seen high it holds all domains in reset, then releases
// them one by one in index order. Supports a software-requested full
// re-sequence and keeps a sticky flag when a qualifier drops after release.
module sys_reset_seq #(
    parameter int NUM_DOMAINS   = 3,
    parameter int NUM_QUAL      = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 8,
    parameter int SW_RST_CYCLES = 32
) (
    input  logic                   soc_clk_i,
    input  logic                   sys_resetn_i,
    input  logic [NUM_QUAL-1:0]    qual_i,
    input  logic                   sw_reset_req_i,
    output logic [NUM_DOMAINS-1:0] rstn_o,
    output logic                   ready_o,
    output logic [2:0]             state_o,
    output logic                   qual_lost_o
);

    // Edge, counted from T0, at which the last domain is released.
    localparam int SEQ_END = HOLD_CYCLES + (NUM_DOMAINS - 1) * STAGE_GAP;
    localparam int CNT_MAX = (SEQ_END > SW_RST_CYCLES) ? SEQ_END : SW_RST_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);
    localparam logic [CW-1:0] SEQ_END_C = CW'(SEQ_END);
    localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] SWRST_C   = CW'(SW_RST_CYCLES);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SWRST   = 3'd4
    } state_t;

    // Count value at which domain k leaves reset.
    function automatic logic [CW-1:0] rel_at(input int k);
        return CW'(HOLD_CYCLES + k * STAGE_GAP);
    endfunction

    logic [SYNC_STAGES-1:0] rst_sync_r;
    logic [NUM_QUAL-1:0]    qual_sync_r [SYNC_STAGES];
    logic                   srst_s;
    logic                   qok_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_inc_s;
    logic [NUM_DOMAINS-1:0] rel_mask_s;
    state_t                 state_r;
    logic [NUM_DOMAINS-1:0] rstn_r;
    logic                   ready_r;
    logic                   qual_lost_r;

    // Reset synchroniser: asynchronous assertion, synchronous release.
    always_ff @(posedge soc_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            rst_sync_r <= '0;
        end else begin
            rst_sync_r <= {rst_sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Per-bit qualifier synchronisers, no filtering.
    always_ff @(posedge soc_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                qual_sync_r[i] <= '0;
            end
        end else begin
            qual_sync_r[0] <= qual_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                qual_sync_r[i] <= qual_sync_r[i-1];
            end
        end
    end

    // The FSM is held cleared until the synchronised reset has released.
    assign srst_s = ~rst_sync_r[SYNC_STAGES-1];
    assign qok_s  = &qual_sync_r[SYNC_STAGES-1];

    // Saturating increment: the counter never wraps.
    always_comb begin
        if (cnt_r >= CNT_MAX_C) begin
            cnt_inc_s = CNT_MAX_C;
        end else begin
            cnt_inc_s = cnt_r + CW'(1);
        end
    end

    // Domains whose release point has been reached by the next count value.
    always_comb begin
        rel_mask_s = '0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            rel_mask_s[k] = (cnt_inc_s >= rel_at(k));
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge soc_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            state_r     <= ST_HOLD;
            cnt_r       <= '0;
            rstn_r      <= '0;
            ready_r     <= 1'b0;
            qual_lost_r <= 1'b0;
        end else if (srst_s) begin
            state_r     <= ST_HOLD;
            cnt_r       <= '0;
            rstn_r      <= '0;
            ready_r     <= 1'b0;
            qual_lost_r <= 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    cnt_r   <= '0;
                    rstn_r  <= '0;
                    ready_r <= 1'b0;
                    if (qok_s) begin
                        state_r <= ST_COUNT;
                    end
                end
                ST_COUNT, ST_RELEASE, ST_RUN: begin
                    if (!qok_s) begin
                        // Loss during COUNT is a silent re-qualify; after release it is sticky.
                        state_r <= ST_HOLD;
                        cnt_r   <= '0;
                        rstn_r  <= '0;
                        ready_r <= 1'b0;
                        if (state_r != ST_COUNT) begin
                            qual_lost_r <= 1'b1;
                        end
                    end else if (sw_reset_req_i && (state_r != ST_COUNT)) begin
                        state_r     <= ST_SWRST;
                        cnt_r       <= '0;
                        rstn_r      <= '0;
                        ready_r     <= 1'b0;
                        qual_lost_r <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        rstn_r <= rel_mask_s;
                        if (cnt_inc_s >= SEQ_END_C) begin
                            state_r <= ST_RUN;
                            ready_r <= 1'b1;
                        end else if (cnt_inc_s >= HOLD_C) begin
                            state_r <= ST_RELEASE;
                        end
                    end
                end
                ST_SWRST: begin
                    // Fixed-length hold; qualifier and request inputs are ignored here.
                    rstn_r  <= '0;
                    ready_r <= 1'b0;
                    if (cnt_inc_s >= SWRST_C) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_HOLD;
                    cnt_r   <= '0;
                    rstn_r  <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign rstn_o      = rstn_r;
    assign ready_o     = ready_r;
    assign state_o     = state_r;
    assign qual_lost_o = qual_lost_r;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Bench for sys_reset_seq: vector table, directed corner sequences and a
// randomized run, all compared every cycle against a timestamp-based model.
module tb_sys_reset_seq;

    localparam int ND   = 3;
    localparam int NQ   = 2;
    localparam int SS   = 2;
    localparam int HC   = 16;
    localparam int SG   = 8;
    localparam int SWC  = 32;
    localparam int LAST = HC + (ND - 1) * SG;

    localparam int PH_IDLE  = 0;
    localparam int PH_SEQ   = 1;
    localparam int PH_SWRST = 2;

    logic          clk        = 1'b0;
    logic          clk_en     = 1'b1;
    logic          sys_resetn = 1'b1;
    logic [NQ-1:0] qual       = '1;
    logic          sw_req     = 1'b0;
    logic [ND-1:0] rstn;
    logic          ready;
    logic [2:0]    state;
    logic          qual_lost;

    int checks = 0;
    int errors = 0;

    sys_reset_seq #(
        .NUM_DOMAINS(ND), .NUM_QUAL(NQ), .SYNC_STAGES(SS),
        .HOLD_CYCLES(HC), .STAGE_GAP(SG), .SW_RST_CYCLES(SWC)
    ) dut (
        .soc_clk_i     (clk),
        .sys_resetn_i  (sys_resetn),
        .qual_i        (qual),
        .sw_reset_req_i(sw_req),
        .rstn_o        (rstn),
        .ready_o       (ready),
        .state_o       (state),
        .qual_lost_o   (qual_lost)
    );

    // Gated free-running clock, period 10.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference model: phase plus timestamps of the last T0 / software reset.
    typedef struct {
        int                 n;
        int                 phase;
        int                 t0;
        int                 ts;
        logic               lost;
        logic [SS*NQ-1:0]   qhist;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.n = 0; r.phase = PH_IDLE; r.t0 = 0; r.ts = 0; r.lost = 1'b0; r.qhist = '0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t c, input logic [NQ-1:0] q, input logic sw);
        model_t r;
        logic   qok;
        int     dprev;
        r       = c;
        r.n     = c.n + 1;
        r.qhist = {c.qhist[SS*NQ-NQ-1:0], q};
        qok     = &c.qhist[SS*NQ-1 -: NQ];
        dprev   = c.n - c.t0;
        if (c.n < SS) begin
            r.phase = PH_IDLE;
            r.lost  = 1'b0;
        end else if (c.phase == PH_IDLE) begin
            if (qok) begin
                r.phase = PH_SEQ;
                r.t0    = r.n;
            end
        end else if (c.phase == PH_SEQ) begin
            if (!qok) begin
                if (dprev >= HC) r.lost = 1'b1;
                r.phase = PH_IDLE;
            end else if (sw && dprev >= HC) begin
                r.phase = PH_SWRST;
                r.ts    = r.n;
                r.lost  = 1'b0;
            end
        end else begin
            if (r.n - c.ts >= SWC) r.phase = PH_IDLE;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_expect(input model_t c);
        logic [ND-1:0] rs;
        logic          rd;
        logic [2:0]    st;
        int            d;
        rs = '0; rd = 1'b0; st = 3'd0;
        d  = c.n - c.t0;
        if (c.phase == PH_SEQ) begin
            for (int k = 0; k < ND; k++) rs[k] = (d >= HC + k * SG);
            rd = (d >= LAST);
            st = (d < HC) ? 3'd1 : (rd ? 3'd3 : 3'd2);
        end else if (c.phase == PH_SWRST) begin
            st = 3'd4;
        end
        return 32'({rs, rd, st, c.lost});
    endfunction

    // Model advances on every clock edge and clears on the asynchronous reset.
    always @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) m <= model_reset();
        else             m <= model_step(m, qual, sw_req);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [ND-1:0] r, input logic rd,
                           input logic [2:0] st, input logic lost);
        chk(name, 32'({rstn, ready, state, qual_lost}), 32'({r, rd, st, lost}));
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model", 32'({rstn, ready, state, qual_lost}), model_expect(m));
    endtask

    task automatic do_reset();
        sys_resetn = 1'b0;
        repeat (3) tick();
        sys_resetn = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            if (state === st) hit = 1'b1;
        end
        chk("wait_state", 32'(hit), 32'd1);
    endtask

    // Called at the sample point just after T0: checks the full release ladder.
    task automatic check_release(input logic lost_exp);
        logic [ND-1:0] e;
        repeat (HC - 1) tick();
        chk_out("pre_release", '0, 1'b0, 3'd1, lost_exp);
        for (int k = 0; k < ND; k++) begin
            if (k > 0) begin
                repeat (SG - 1) tick();
                e = ND'((1 << k) - 1);
                chk_out("gap_hold", e, 1'b0, 3'd2, lost_exp);
            end
            tick();
            e = ND'((1 << (k + 1)) - 1);
            chk_out("release_step", e, (k == ND - 1), (k == ND - 1) ? 3'd3 : 3'd2, lost_exp);
        end
    endtask

    typedef struct {
        logic [NQ-1:0] qual;
        logic          sw;
        int            n;
        logic [ND-1:0] rstn;
        logic          ready;
        logic [2:0]    st;
        logic          lost;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [NQ-1:0] q, input logic sw, input int n, input logic [ND-1:0] r,
                       input logic rd, input logic [2:0] st, input logic lost);
        vec_t v;
        v.qual = q; v.sw = sw; v.n = n; v.rstn = r; v.ready = rd; v.st = st; v.lost = lost;
        tbl.push_back(v);
    endtask

    initial begin
        // Edges counted from reset release; T0 is edge 3.
        add(2'b11, 1'b0,  3, 3'b000, 1'b0, 3'd1, 1'b0);
        add(2'b11, 1'b0, 15, 3'b000, 1'b0, 3'd1, 1'b0);
        add(2'b11, 1'b0,  1, 3'b001, 1'b0, 3'd2, 1'b0);
        add(2'b11, 1'b0,  7, 3'b001, 1'b0, 3'd2, 1'b0);
        add(2'b11, 1'b0,  1, 3'b011, 1'b0, 3'd2, 1'b0);
        add(2'b11, 1'b0,  7, 3'b011, 1'b0, 3'd2, 1'b0);
        add(2'b11, 1'b0,  1, 3'b111, 1'b1, 3'd3, 1'b0);
        add(2'b11, 1'b0, 10, 3'b111, 1'b1, 3'd3, 1'b0);
        add(2'b11, 1'b1,  1, 3'b000, 1'b0, 3'd4, 1'b0);
        add(2'b11, 1'b0, 31, 3'b000, 1'b0, 3'd4, 1'b0);
        add(2'b11, 1'b0,  1, 3'b000, 1'b0, 3'd0, 1'b0);
        add(2'b11, 1'b0,  1, 3'b000, 1'b0, 3'd1, 1'b0);
        add(2'b11, 1'b0, 16, 3'b001, 1'b0, 3'd2, 1'b0);
        add(2'b11, 1'b0, 16, 3'b111, 1'b1, 3'd3, 1'b0);
        add(2'b10, 1'b0,  2, 3'b111, 1'b1, 3'd3, 1'b0);
        add(2'b10, 1'b0,  1, 3'b000, 1'b0, 3'd0, 1'b1);
        add(2'b11, 1'b0,  2, 3'b000, 1'b0, 3'd0, 1'b1);
        add(2'b11, 1'b0,  1, 3'b000, 1'b0, 3'd1, 1'b1);
        add(2'b11, 1'b0, 16, 3'b001, 1'b0, 3'd2, 1'b1);
        add(2'b11, 1'b1,  1, 3'b000, 1'b0, 3'd4, 1'b0);
        add(2'b11, 1'b0, 32, 3'b000, 1'b0, 3'd0, 1'b0);

        #1;
        qual = 2'b11;
        do_reset();
        chk_out("reset_state", '0, 1'b0, 3'd0, 1'b0);
        foreach (tbl[i]) begin
            qual   = tbl[i].qual;
            sw_req = tbl[i].sw;
            repeat (tbl[i].n) tick();
            chk_out($sformatf("vec%0d", i), tbl[i].rstn, tbl[i].ready, tbl[i].st, tbl[i].lost);
        end
        sw_req = 1'b0;

        // Partial qualifiers hold; drop at T0+10 returns to HOLD silently.
        qual = 2'b01;
        do_reset();
        repeat (100) tick();
        chk_out("partial_qual", '0, 1'b0, 3'd0, 1'b0);
        qual = 2'b11;
        wait_state(3'd1, 6);
        repeat (7) tick();
        qual = 2'b01;
        repeat (2) tick();
        chk_out("count_t0p9", '0, 1'b0, 3'd1, 1'b0);
        tick();
        chk_out("count_drop", '0, 1'b0, 3'd0, 1'b0);
        qual = 2'b11;
        wait_state(3'd1, 6);
        check_release(1'b0);

        // Qualifier loss in RUN.
        qual = 2'b10;
        repeat (2) tick();
        chk_out("run_before_loss", 3'b111, 1'b1, 3'd3, 1'b0);
        tick();
        chk_out("run_loss", '0, 1'b0, 3'd0, 1'b1);
        qual = 2'b11;
        wait_state(3'd1, 6);
        check_release(1'b1);

        // Software reset from RUN with the sticky flag set.
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk_out("swrst_enter", '0, 1'b0, 3'd4, 1'b0);
        repeat (SWC - 1) tick();
        chk_out("swrst_last", '0, 1'b0, 3'd4, 1'b0);
        tick();
        chk_out("swrst_exit", '0, 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("swrst_requal", '0, 1'b0, 3'd1, 1'b0);
        check_release(1'b0);

        // Asynchronous reset mid-RELEASE, between edges.
        do_reset();
        wait_state(3'd1, 6);
        repeat (20) tick();
        chk_out("mid_release", 3'b001, 1'b0, 3'd2, 1'b0);
        @(posedge clk);
        #2;
        sys_resetn = 1'b0;
        #1;
        chk_out("async_rst", '0, 1'b0, 3'd0, 1'b0);
        tick();
        sys_resetn = 1'b1;
        wait_state(3'd1, 6);
        repeat (20) tick();
        chk_out("mid_release2", 3'b001, 1'b0, 3'd2, 1'b0);
        clk_en = 1'b0;
        #23;
        sys_resetn = 1'b0;
        #1;
        chk_out("async_rst_noclk", '0, 1'b0, 3'd0, 1'b0);
        #10;
        clk_en = 1'b1;

        // Qualifier loss and software request on the same edge: loss wins.
        do_reset();
        wait_state(3'd3, 40);
        qual = 2'b10;
        repeat (2) tick();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk_out("loss_vs_sw", '0, 1'b0, 3'd0, 1'b1);
        tick();
        chk_out("sw_dropped", '0, 1'b0, 3'd0, 1'b1);
        qual = 2'b11;

        // Randomized run checked against the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) qual = NQ'($urandom);
            else if (qual != '1 && $urandom_range(0, 9) == 0) qual = '1;
            sw_req = ($urandom_range(0, 39) == 0);
            if (!sys_resetn) sys_resetn = 1'b1;
            else if ($urandom_range(0, 999) == 0) sys_resetn = 1'b0;
            tick();
        end
        sw_req     = 1'b0;
        sys_resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
